deser_demux8: RTL and testbench



---
 rtl/mux_pkg.sv | 17 +
 rtl/deser_demux8_dec3to8.sv | 15 +
 rtl/deser_demux8.sv | 94 +++++++++
 tb/tb_deser_demux8.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared widths and types for the bit-select mux family (8:1 select and 1:8 assemble).
package mux_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef logic [WIDTH-1:0] byte_t;
  typedef logic [SEL_W-1:0] sel_t;

  localparam byte_t FULL_MASK = '1;

  // Overwrite the positions marked in onehot with the value b, leaving the rest untouched.
  function automatic byte_t merge_bit(input byte_t acc, input byte_t onehot, input logic b);
    return (acc & ~onehot) | ({WIDTH{b}} & onehot);
  endfunction

endpackage

// File: rtl/deser_demux8_dec3to8.sv
// Combinational one-hot decoder: bit gi of onehot is set when sel equals gi.
module dec3to8
  import mux_pkg::*;
(
  input  sel_t  sel,
  output byte_t onehot
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign onehot[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/deser_demux8.sv
// Bit-addressed byte assembler: collects eight selected bit writes into a byte and
// hands it off through a single-entry valid/ready output slot.
module deser_demux8
  import mux_pkg::*;
#(
  parameter int WIDTH = mux_pkg::WIDTH,
  parameter int SEL_W = mux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovw,
  output logic             out_valid,
  input  logic             out_ready
);

  byte_t acc_reg, acc_next;
  byte_t mask_reg, mask_next;
  logic  ovw_reg, ovw_next;
  byte_t out_data_reg, out_data_next;
  logic  out_ovw_reg, out_ovw_next;
  logic  out_valid_reg, out_valid_next;

  byte_t sel_onehot;
  logic  wr_en;
  logic  slot_free;

  dec3to8 u_dec (
    .sel    (in_sel),
    .onehot (sel_onehot)
  );

  // Input stalls only while a complete byte is parked in acc waiting for the slot.
  assign in_ready  = (mask_reg != FULL_MASK);
  assign wr_en     = in_valid && in_ready;
  assign slot_free = !out_valid_reg || out_ready;

  always_comb begin
    acc_next       = acc_reg;
    mask_next      = mask_reg;
    ovw_next       = ovw_reg;
    out_data_next  = out_data_reg;
    out_ovw_next   = out_ovw_reg;
    out_valid_next = out_valid_reg;

    if (wr_en) begin
      acc_next  = merge_bit(acc_reg, sel_onehot, in_bit);
      mask_next = mask_reg | sel_onehot;
      ovw_next  = ovw_reg | (|(mask_reg & sel_onehot));
    end

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    // Covers both the completing write and a byte already waiting in FULL_WAIT;
    // a load overrides the drain so out_valid stays high across back-to-back bytes.
    if ((mask_next == FULL_MASK) && slot_free) begin
      out_data_next  = acc_next;
      out_ovw_next   = ovw_next;
      out_valid_next = 1'b1;
      acc_next       = '0;
      mask_next      = '0;
      ovw_next       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      mask_reg      <= '0;
      ovw_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_ovw_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      mask_reg      <= mask_next;
      ovw_reg       <= ovw_next;
      out_data_reg  <= out_data_next;
      out_ovw_reg   <= out_ovw_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ovw   = out_ovw_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_deser_demux8.sv
// Self-checking bench for deser_demux8: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based model of emitted bytes.
module tb_deser_demux8;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit;
  logic [2:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_ovw;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;
  bit rand_ready = 1'b0;

  // Model: bits gathered for the byte in progress, plus the bytes owed downstream
  // ({ovw, data}); the head is the one that must currently be on the output.
  bit [7:0] m_bits;
  bit [7:0] m_written;
  bit       m_dup;
  bit [8:0] exp_q[$];

  deser_demux8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovw   (out_ovw),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard sampled on the falling edge, where inputs and outputs are settled
  // for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_bits    = '0;
      m_written = '0;
      m_dup     = 1'b0;
    end else begin
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL sb_out_valid: got %b, expected %b", out_valid, exp_q.size() != 0);
      end
      checks++;
      if (in_ready !== (exp_q.size() < 2)) begin
        failures++;
        $display("FAIL sb_in_ready: got %b, expected %b", in_ready, exp_q.size() < 2);
      end
      if (exp_q.size() != 0 && out_valid === 1'b1) begin
        checks++;
        if ({out_ovw, out_data} !== exp_q[0]) begin
          failures++;
          $display("FAIL sb_out_byte: got ovw=%b data=%h, expected ovw=%b data=%h",
                   out_ovw, out_data, exp_q[0][8], exp_q[0][7:0]);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        if (m_written[in_sel]) m_dup = 1'b1;
        m_written[in_sel] = 1'b1;
        m_bits[in_sel]    = in_bit;
        if (&m_written) begin
          exp_q.push_back({m_dup, m_bits});
          m_bits    = '0;
          m_written = '0;
          m_dup     = 1'b0;
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input logic [2:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_sel   = s;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout: in_ready stuck at %b, required 1 within 50 cycles", in_ready);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  // mode 0: sel 0..7, mode 1: sel 7..0, mode 2: random permutation
  task automatic send_byte(input logic [7:0] d, input int mode);
    int perm[8];
    for (int i = 0; i < 8; i++) perm[i] = (mode == 1) ? 7 - i : i;
    if (mode == 2) begin
      for (int i = 7; i > 0; i--) begin
        int j = int'($urandom_range(0, i));
        int t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      drive_bit(d[perm[i]], 3'(perm[i]));
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sel = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    checks++;
    if (out_ovw !== 1'b0) begin failures++; $display("FAIL reset_out_ovw: got %b, expected 0", out_ovw); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_fill(input logic [7:0] d, input int mode, input string name);
    out_ready = 1'b1;
    send_byte(d, mode);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_ovw !== 1'b0) begin
      failures++;
      $display("FAIL %s_byte: got v=%b data=%h ovw=%b, expected v=1 data=%h ovw=0",
               name, out_valid, out_data, out_ovw, d);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_pulse: got out_valid=%b, expected 0", name, out_valid); end
    $display("%s: byte %h", name, d);
  endtask

  task automatic test_duplicate();
    logic [7:0] d;
    out_ready = 1'b1;
    drive_bit(1'b0, 3'd3);
    drive_bit(1'b1, 3'd3);
    for (int s = 0; s < 8; s++) if (s != 3) drive_bit(1'b0, 3'(s));
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h08 || out_ovw !== 1'b1) begin
      failures++;
      $display("FAIL dup_byte: got v=%b data=%h ovw=%b, expected v=1 data=08 ovw=1", out_valid, out_data, out_ovw);
    end
    d = 8'($urandom);
    send_byte(d, 2);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_ovw !== 1'b0) begin
      failures++;
      $display("FAIL dup_next_byte: got v=%b data=%h ovw=%b, expected v=1 data=%h ovw=0", out_valid, out_data, out_ovw, d);
    end
    idle_cycle();
    $display("test_duplicate: dup byte 08 then %h", d);
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send_byte(8'h11, 2);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL bp_first: got v=%b data=%h, expected v=1 data=11", out_valid, out_data);
    end
    send_byte(8'h22, 2);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h11) begin
      failures++;
      $display("FAIL bp_stall: got in_ready=%b data=%h, expected in_ready=0 data=11", in_ready, out_data);
    end
    repeat (3) idle_cycle();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: got in_ready=%b v=%b data=%h, expected in_ready=0 v=1 data=11", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got v=%b data=%h in_ready=%b, expected v=1 data=22 in_ready=1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got out_valid=%b, expected 0", out_valid); end
    $display("test_back_pressure: 11 then 22");
  endtask

  task automatic test_reset_mid_byte();
    int early = 0;
    out_ready = 1'b0;
    send_byte(8'($urandom), 2);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)), 3'(i));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_state: got v=%b data=%h in_ready=%b, expected v=0 data=00 in_ready=1", out_valid, out_data, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      drive_bit(i >= 4, 3'(i));
      if (i < 7 && out_valid !== 1'b0) early++;
    end
    in_valid = 1'b0;
    checks++;
    if (early != 0) begin failures++; $display("FAIL rst_mid_stale: got %0d early out_valid cycles, expected 0", early); end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hF0 || out_ovw !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_byte: got v=%b data=%h ovw=%b, expected v=1 data=F0 ovw=0", out_valid, out_data, out_ovw);
    end
    idle_cycle();
    $display("test_reset_mid_byte: byte F0");
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int stalls = 0;
    int misplaced = 0;
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      logic [7:0] bv = 8'(k);
      for (int i = 0; i < 8; i++) begin
        drive_bit(bv[i], 3'(i));
        if (out_valid === 1'b1) pulses++;
        if (out_valid !== (i == 7)) misplaced++;
        if (in_ready !== 1'b1) stalls++;
      end
      checks++;
      if (out_data !== bv) begin failures++; $display("FAIL b2b_data: got %h, expected %h", out_data, bv); end
    end
    in_valid = 1'b0;
    checks++;
    if (pulses != 3 || misplaced != 0) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d pulses (%0d misplaced), expected 3 spaced 8 apart", pulses, misplaced);
    end
    checks++;
    if (stalls != 0) begin failures++; $display("FAIL b2b_in_ready: got %0d low cycles, expected 0", stalls); end
    idle_cycle();
    $display("test_back_to_back: 01 02 03");
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) drive_bit(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      send_byte(8'($urandom), 2);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (4) idle_cycle();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: got %0d owed bytes, out_valid=%b, expected 0 and 0", exp_q.size(), out_valid);
    end
    $display("test_random: 40 bytes");
  endtask

  initial begin
    test_reset();
    test_fill(8'hA5, 0, "in_order");
    test_fill(8'h3C, 1, "reverse");
    test_duplicate();
    test_back_pressure();
    test_reset_mid_byte();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
